// File: rtl/pwm_multi_if.sv
// Bus bundle for pwm_multi: enables, duty update strobe and flat duty bus in,
// registered PWM outputs and period/update status out.
interface pwm_multi_if #(
    parameter int N = 4,
    parameter int W = 6
);
    logic             en;
    logic [N-1:0]     ch_en;
    logic             upd;
    logic [N*W-1:0]   duty_in;
    logic [N-1:0]     pwm_out;
    logic             period_end;
    logic             pending;

    modport master (
        output en, ch_en, upd, duty_in,
        input  pwm_out, period_end, pending
    );

    modport slave (
        input  en, ch_en, upd, duty_in,
        output pwm_out, period_end, pending
    );
endinterface

// File: rtl/pwm_multi.sv
// N-channel PWM sharing one prescaled W-bit period counter; duty changes land only on period wraps.
// Optional macro PWM_FADE_EN: shadow duties ramp one step per period toward the staged values.
module pwm_multi #(
    parameter int N       = 4,
    parameter int W       = 6,
    parameter int DIV     = 1,
    parameter int STAGGER = 0
) (
    input  logic       CLOCK_50,
    input  logic       rst,
    pwm_multi_if.slave bus
);
    localparam int            PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [W-1:0]  CNT_LAST   = {W{1'b1}};

    logic [PW-1:0]       prescaler;
    logic                tick;
    logic                wrap;
    logic [W-1:0]        cnt;
    logic [N-1:0][W-1:0] staging;
    logic [N-1:0][W-1:0] shadow;
    logic [N-1:0][W-1:0] shadow_next;
    logic [N-1:0][W-1:0] phase;
    logic                apply_done;
    logic [N-1:0]        pwm_next;
    logic [N-1:0]        pwm_q;
    logic                period_end_q;
    logic                pending_q;

    // With DIV=1 the prescaler sits at zero and tick is permanently high.
    assign tick = (prescaler == PRESC_LAST);
    assign wrap = tick && (cnt == CNT_LAST);

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            period_end_q <= 1'b0;
        end else begin
            if (tick) begin
                cnt <= cnt + W'(1);
            end
            period_end_q <= wrap;
        end
    end

`ifdef PWM_FADE_EN
    // Each channel moves one step toward its staged duty per period.
    always_comb begin
        apply_done = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (shadow[i] < staging[i]) begin
                shadow_next[i] = shadow[i] + W'(1);
            end else if (shadow[i] > staging[i]) begin
                shadow_next[i] = shadow[i] - W'(1);
            end else begin
                shadow_next[i] = shadow[i];
            end
            if (shadow_next[i] != staging[i]) begin
                apply_done = 1'b0;
            end
        end
    end
`else
    assign shadow_next = staging;
    assign apply_done  = 1'b1;
`endif

    // A strobe coinciding with the wrap still lets the old staging reach shadow,
    // while the new capture keeps pending set for the following wrap.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            staging   <= '0;
            shadow    <= '0;
            pending_q <= 1'b0;
        end else begin
            if (wrap && pending_q) begin
                shadow <= shadow_next;
            end
            if (bus.upd) begin
                staging   <= bus.duty_in;
                pending_q <= 1'b1;
            end else if (wrap && pending_q && apply_done) begin
                pending_q <= 1'b0;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            phase[i]    = cnt + W'(i * STAGGER);
            pwm_next[i] = bus.en & bus.ch_en[i] & (phase[i] < shadow[i]);
        end
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= pwm_next;
        end
    end

    assign bus.pwm_out    = pwm_q;
    assign bus.period_end = period_end_q;
    assign bus.pending    = pending_q;
endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: three instances (plain, DIV=3, STAGGER=4) measured
// period by period against expected high counts queued when each duty update is driven.
module tb_pwm_multi;
    logic CLOCK_50;
    logic rst;

    int tests_run;
    int tests_failed;
    int sel;

    logic [3:0] mon_pwm;
    logic       mon_pe;
    logic       mon_pend;

    int meas_hi[4];
    int meas_first[4];
    int meas_len;
    int meas_sync;

    typedef struct packed {
        logic [3:0][7:0] hi;
        logic [7:0]      len;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    pwm_multi_if #(.N(4), .W(4)) a_if ();
    pwm_multi_if #(.N(4), .W(4)) b_if ();
    pwm_multi_if #(.N(4), .W(4)) c_if ();

    pwm_multi #(.N(4), .W(4), .DIV(1), .STAGGER(0)) dut_a (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .bus      (a_if)
    );

    pwm_multi #(.N(4), .W(4), .DIV(3), .STAGGER(0)) dut_b (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .bus      (b_if)
    );

    pwm_multi #(.N(4), .W(4), .DIV(1), .STAGGER(4)) dut_c (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .bus      (c_if)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #10 CLOCK_50 = ~CLOCK_50;
    end

    always_comb begin
        mon_pwm  = a_if.pwm_out;
        mon_pe   = a_if.period_end;
        mon_pend = a_if.pending;
        if (sel == 1) begin
            mon_pwm  = b_if.pwm_out;
            mon_pe   = b_if.period_end;
            mon_pend = b_if.pending;
        end else if (sel == 2) begin
            mon_pwm  = c_if.pwm_out;
            mon_pe   = c_if.period_end;
            mon_pend = c_if.pending;
        end
    end

    function automatic exp_t mk_exp(input int h0, input int h1, input int h2, input int h3, input int len);
        exp_t r;
        r.hi[0] = 8'(h0);
        r.hi[1] = 8'(h1);
        r.hi[2] = 8'(h2);
        r.hi[3] = 8'(h3);
        r.len   = 8'(len);
        return r;
    endfunction

    task automatic sync_pe(input int limit);
        meas_sync = 0;
        do begin
            @(negedge CLOCK_50);
            meas_sync++;
        end while (mon_pe !== 1'b1 && meas_sync < limit);
    endtask

    // Accumulates one period: from the cycle after a period_end up to and including the next one.
    task automatic measure(input int limit);
        for (int i = 0; i < 4; i++) begin
            meas_hi[i]    = 0;
            meas_first[i] = 0;
        end
        meas_len = 0;
        do begin
            @(negedge CLOCK_50);
            meas_len++;
            for (int i = 0; i < 4; i++) begin
                if (mon_pwm[i] === 1'b1) begin
                    meas_hi[i]++;
                    if (meas_first[i] == 0) meas_first[i] = meas_len;
                end
            end
        end while (mon_pe !== 1'b1 && meas_len < limit);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge CLOCK_50);
        tests_run++;
        if ({a_if.pwm_out, a_if.period_end, a_if.pending} !== 6'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_a_outputs: got %b, want 000000", {a_if.pwm_out, a_if.period_end, a_if.pending});
        end
        tests_run++;
        if ({b_if.pwm_out, c_if.pwm_out} !== 8'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_bc_pwm: got %b, want 00000000", {b_if.pwm_out, c_if.pwm_out});
        end
        rst = 1'b0;
        sel = 0;
        sync_pe(40);
        tests_run++;
        if (meas_sync !== 16) begin
            tests_failed++;
            $display("[TB] FAIL reset_first_wrap: got %0d clocks, want 16", meas_sync);
        end
        sb.push_back(mk_exp(0, 0, 0, 0, 16));
        e = sb.pop_front();
        measure(40);
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (meas_hi[i] !== int'(e.hi[i])) begin
                tests_failed++;
                $display("[TB] FAIL reset_high_ch%0d: got %0d, want %0d", i, meas_hi[i], e.hi[i]);
            end
        end
        tests_run++;
        if (meas_len !== int'(e.len)) begin
            tests_failed++;
            $display("[TB] FAIL reset_period_len: got %0d, want %0d", meas_len, e.len);
        end
    endtask

    task automatic test_duty_basic;
        a_if.duty_in = {4'd15, 4'd8, 4'd1, 4'd0};
        a_if.upd     = 1'b1;
        @(negedge CLOCK_50);
        a_if.upd = 1'b0;
        tests_run++;
        if (mon_pend !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL basic_pending_set: got %b, want 1", mon_pend);
        end
        for (int k = 0; k < 3; k++) sb.push_back(mk_exp(0, 1, 8, 15, 16));
        sync_pe(40);
        tests_run++;
        if (mon_pend !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL basic_pending_clear: got %b, want 0", mon_pend);
        end
        for (int k = 0; k < 3; k++) begin
            e = sb.pop_front();
            measure(40);
            for (int i = 0; i < 4; i++) begin
                tests_run++;
                if (meas_hi[i] !== int'(e.hi[i])) begin
                    tests_failed++;
                    $display("[TB] FAIL basic_high_p%0d_ch%0d: got %0d, want %0d", k, i, meas_hi[i], e.hi[i]);
                end
            end
            tests_run++;
            if (meas_len !== int'(e.len)) begin
                tests_failed++;
                $display("[TB] FAIL basic_period_len_p%0d: got %0d, want %0d", k, meas_len, e.len);
            end
        end
    endtask

    task automatic test_mid_period_update;
        int hi2;
        hi2 = 0;
        for (int j = 1; j <= 16; j++) begin
            @(negedge CLOCK_50);
            if (mon_pwm[2] === 1'b1) hi2++;
            if (j == 5) begin
                a_if.duty_in = {4'd15, 4'd3, 4'd1, 4'd0};
                a_if.upd     = 1'b1;
            end
            if (j == 6) begin
                a_if.upd = 1'b0;
                tests_run++;
                if (mon_pend !== 1'b1) begin
                    tests_failed++;
                    $display("[TB] FAIL mid_pending_set: got %b, want 1", mon_pend);
                end
            end
            if (j == 16) begin
                tests_run++;
                if ({mon_pe, mon_pend} !== 2'b10) begin
                    tests_failed++;
                    $display("[TB] FAIL mid_wrap_state: got pe/pend %b, want 10", {mon_pe, mon_pend});
                end
            end
        end
        tests_run++;
        if (hi2 !== 8) begin
            tests_failed++;
            $display("[TB] FAIL mid_old_duty_kept: got %0d, want 8", hi2);
        end
        sb.push_back(mk_exp(0, 1, 3, 15, 16));
        e = sb.pop_front();
        measure(40);
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (meas_hi[i] !== int'(e.hi[i])) begin
                tests_failed++;
                $display("[TB] FAIL mid_high_ch%0d: got %0d, want %0d", i, meas_hi[i], e.hi[i]);
            end
        end
    endtask

    task automatic test_wrap_boundary;
        for (int j = 1; j <= 16; j++) begin
            @(negedge CLOCK_50);
            a_if.upd = 1'b0;
            if (j == 3)  begin a_if.duty_in = {4'd15, 4'd3, 4'd1, 4'd5}; a_if.upd = 1'b1; end
            if (j == 7)  begin a_if.duty_in = {4'd15, 4'd3, 4'd1, 4'd7}; a_if.upd = 1'b1; end
            if (j == 15) begin a_if.duty_in = {4'd15, 4'd3, 4'd1, 4'd2}; a_if.upd = 1'b1; end
            if (j == 16) begin
                tests_run++;
                if ({mon_pe, mon_pend} !== 2'b11) begin
                    tests_failed++;
                    $display("[TB] FAIL wrap_upd_state: got pe/pend %b, want 11", {mon_pe, mon_pend});
                end
            end
        end
        sb.push_back(mk_exp(7, 1, 3, 15, 16));
        sb.push_back(mk_exp(2, 1, 3, 15, 16));
        for (int k = 0; k < 2; k++) begin
            e = sb.pop_front();
            measure(40);
            for (int i = 0; i < 4; i++) begin
                tests_run++;
                if (meas_hi[i] !== int'(e.hi[i])) begin
                    tests_failed++;
                    $display("[TB] FAIL wrap_high_p%0d_ch%0d: got %0d, want %0d", k, i, meas_hi[i], e.hi[i]);
                end
            end
            tests_run++;
            if (mon_pend !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL wrap_pending_p%0d: got %b, want 0", k, mon_pend);
            end
        end
    endtask

    task automatic test_enables;
        a_if.en = 1'b0;
        sb.push_back(mk_exp(0, 0, 0, 0, 16));
        e = sb.pop_front();
        measure(40);
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (meas_hi[i] !== int'(e.hi[i])) begin
                tests_failed++;
                $display("[TB] FAIL en_off_high_ch%0d: got %0d, want %0d", i, meas_hi[i], e.hi[i]);
            end
        end
        tests_run++;
        if (meas_len !== int'(e.len)) begin
            tests_failed++;
            $display("[TB] FAIL en_off_period_len: got %0d, want %0d", meas_len, e.len);
        end
        a_if.en    = 1'b1;
        a_if.ch_en = 4'b1010;
        sb.push_back(mk_exp(0, 1, 0, 15, 16));
        e = sb.pop_front();
        measure(40);
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (meas_hi[i] !== int'(e.hi[i])) begin
                tests_failed++;
                $display("[TB] FAIL ch_en_high_ch%0d: got %0d, want %0d", i, meas_hi[i], e.hi[i]);
            end
        end
        a_if.ch_en = 4'hF;
    endtask

    task automatic test_prescaler;
        sel = 1;
        sync_pe(200);
        b_if.duty_in = {4'd4, 4'd4, 4'd4, 4'd4};
        b_if.upd     = 1'b1;
        @(negedge CLOCK_50);
        b_if.upd = 1'b0;
        tests_run++;
        if (mon_pend !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL div_pending_set: got %b, want 1", mon_pend);
        end
        sb.push_back(mk_exp(12, 12, 12, 12, 48));
        sync_pe(200);
        e = sb.pop_front();
        measure(200);
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (meas_hi[i] !== int'(e.hi[i])) begin
                tests_failed++;
                $display("[TB] FAIL div_high_ch%0d: got %0d, want %0d", i, meas_hi[i], e.hi[i]);
            end
        end
        tests_run++;
        if (meas_len !== int'(e.len)) begin
            tests_failed++;
            $display("[TB] FAIL div_period_len: got %0d, want %0d", meas_len, e.len);
        end
    endtask

    task automatic test_stagger;
        int want_first;
        sel = 2;
        sync_pe(40);
        c_if.duty_in = {4'd4, 4'd4, 4'd4, 4'd4};
        c_if.upd     = 1'b1;
        @(negedge CLOCK_50);
        c_if.upd = 1'b0;
        sb.push_back(mk_exp(4, 4, 4, 4, 16));
        sync_pe(40);
        e = sb.pop_front();
        measure(40);
        for (int i = 0; i < 4; i++) begin
            want_first = ((16 - 4 * i) % 16) + 1;
            tests_run++;
            if (meas_hi[i] !== int'(e.hi[i])) begin
                tests_failed++;
                $display("[TB] FAIL stagger_high_ch%0d: got %0d, want %0d", i, meas_hi[i], e.hi[i]);
            end
            tests_run++;
            if (meas_first[i] !== want_first) begin
                tests_failed++;
                $display("[TB] FAIL stagger_rise_ch%0d: got step %0d, want %0d", i, meas_first[i], want_first);
            end
        end
        tests_run++;
        if (meas_len !== int'(e.len)) begin
            tests_failed++;
            $display("[TB] FAIL stagger_period_len: got %0d, want %0d", meas_len, e.len);
        end
    endtask

    task automatic test_reset_mid;
        sel = 0;
        sync_pe(40);
        for (int j = 1; j <= 9; j++) begin
            @(negedge CLOCK_50);
            a_if.upd = 1'b0;
            if (j == 3) begin
                a_if.duty_in = {4'd9, 4'd9, 4'd9, 4'd9};
                a_if.upd     = 1'b1;
            end
        end
        tests_run++;
        if ({mon_pwm, mon_pend} !== 5'b10001) begin
            tests_failed++;
            $display("[TB] FAIL pre_reset_state: got pwm/pend %b, want 10001", {mon_pwm, mon_pend});
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if ({mon_pwm, mon_pe, mon_pend} !== 6'b0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset_outputs: got %b, want 000000", {mon_pwm, mon_pe, mon_pend});
        end
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        rst = 1'b0;
        sync_pe(40);
        tests_run++;
        if (meas_sync !== 16) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_first_wrap: got %0d clocks, want 16", meas_sync);
        end
        measure(40);
        tests_run++;
        if ({meas_hi[3], meas_hi[2], meas_hi[1], meas_hi[0]} !== 128'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_shadow: got highs %0d %0d %0d %0d, want 0 0 0 0", meas_hi[0], meas_hi[1], meas_hi[2], meas_hi[3]);
        end
        tests_run++;
        if (mon_pend !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_pending: got %b, want 0", mon_pend);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        sel          = 0;
        rst          = 1'b1;
        a_if.en = 1'b1; a_if.ch_en = 4'hF; a_if.upd = 1'b0; a_if.duty_in = '0;
        b_if.en = 1'b1; b_if.ch_en = 4'hF; b_if.upd = 1'b0; b_if.duty_in = '0;
        c_if.en = 1'b1; c_if.ch_en = 4'hF; c_if.upd = 1'b0; c_if.duty_in = '0;

        test_reset;
        test_duty_basic;
        test_mid_period_update;
        test_wrap_boundary;
        test_enables;
        test_prescaler;
        test_stagger;
        test_reset_mid;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
